reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of two, minimum 2; AW = log2(NREG) is derived internally.
REQ-003 SHALL have port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have ports we0 input 1, wa0 input AW, wd0 input XLEN: write port 0, ALU writeback.
REQ-006 SHALL have ports we1 input 1, wa1 input AW, wd1 input XLEN: write port 1, load writeback.
REQ-007 SHALL have ports ra1, ra2  input  AW: read addresses.
REQ-008 SHALL have ports rd1, rd2  output  XLEN: read data.
REQ-009 SHALL have ports alloc_en input 1, alloc_addr input AW: mark a destination register pending at issue.
REQ-010 SHALL have ports busy1, busy2  output  1: pending status of ra1 and ra2.
REQ-011 SHALL have port busy_cnt  output  AW+1: number of pending registers.

Function
REQ-012 SHALL write wdN to register waN on the rising edge when weN=1 and waN!=0.
REQ-013 SHALL never store to register 0; rd for address 0 SHALL read 0 and busy for address 0 SHALL read 0 under all inputs.
REQ-014 SHALL have port 0 take precedence over port 1 when both write the same nonzero address in one cycle; port 1 data is dropped.
REQ-015 SHALL read combinationally with same-cycle bypass: rdX = wd0 if we0 and wa0==raX!=0; else wd1 if we1 and wa1==raX!=0; else stored value.
REQ-016 SHALL keep one busy bit per register, updated on the rising edge.
REQ-017 SHALL set busy[alloc_addr] when alloc_en=1 and alloc_addr!=0.
REQ-018 SHALL clear busy[waN] when weN=1 and waN!=0, for each write port.
REQ-019 SHALL let set win when alloc and a clear target the same register in one cycle; the register stays busy for the new producer.
REQ-020 SHALL leave a busy bit set by an alloc of an already-busy register set.
REQ-021 SHALL leave the busy bit and data update unaffected when a write targets a non-busy register; the data is written normally.
REQ-022 SHALL output busyX = busy[raX] & ~(clear of raX this cycle), so that a bypassed read is not reported busy; a same-cycle alloc of raX SHALL NOT assert busyX until the next cycle.
REQ-023 SHALL output busy_cnt as the registered population count of busy bits, range 0..NREG-1, updated in the same edge as the bits.
REQ-024 SHALL implement reads, bypass and busy outputs as pure combinational paths with zero latency; writes and busy updates SHALL have one-edge latency.

Reset
REQ-025 SHALL, while rst=1, immediately and regardless of clk, clear all registers to 0, clear all busy bits and set busy_cnt=0.
REQ-026 SHALL ignore writes and allocs while rst=1; the first update is the first rising edge after rst falls.
REQ-027 SHALL keep the rd bypass paths live during reset: rd reflects wd when the write conditions hold, else 0.

Verification
REQ-028 Reset with rst pulsed mid-cycle after writing x5=0xDEADBEEF -> rd1 for ra1=5 is 0 before the next edge; busy_cnt=0.
REQ-029 Write x0: we0=1, wa0=0, wd0=0xFFFFFFFF; next cycle ra1=0 -> rd1=0, busy1=0; alloc_en=1 at alloc_addr=0 -> busy_cnt stays 0.
REQ-030 Dual-write conflict: we0 and we1 both target x7, wd0=0x11, wd1=0x22 -> during the cycle rd1(ra1=7)=0x11; after the edge x7=0x11.
REQ-031 Scoreboard round trip: alloc x3 -> busy1(ra1=3)=1, busy_cnt=1; we1 x3=0x55 cycle -> busy1=0 and rd1=0x55 in that cycle; after the edge busy_cnt=0.
REQ-032 Alloc/clear collision: x9 busy, then same cycle we0 x9=0xA and alloc x9 -> after the edge x9=0xA, busy[9]=1, busy_cnt unchanged.
REQ-033 Parameter sweep: XLEN=64, NREG=16; alloc all x1..x15 -> busy_cnt=15; write-all then read-all matches with no aliasing.

Source files
------------

// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero; reads and busy outputs bypass same-cycle writes.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we0,
  input  logic [$clog2(NREG)-1:0]   wa0,
  input  logic [XLEN-1:0]           wd0,
  input  logic                      we1,
  input  logic [$clog2(NREG)-1:0]   wa1,
  input  logic [XLEN-1:0]           wd1,
  input  logic [$clog2(NREG)-1:0]   ra1,
  input  logic [$clog2(NREG)-1:0]   ra2,
  output logic [XLEN-1:0]           rd1,
  output logic [XLEN-1:0]           rd2,
  input  logic                      alloc_en,
  input  logic [$clog2(NREG)-1:0]   alloc_addr,
  output logic                      busy1,
  output logic                      busy2,
  output logic [$clog2(NREG):0]     busy_cnt
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic            clr0;
  logic            clr1;
  logic            wr1;
  logic            set_a;

  assign clr0  = we0 && (wa0 != '0);
  assign clr1  = we1 && (wa1 != '0);
  assign wr1   = clr1 && !(clr0 && (wa0 == wa1));
  assign set_a = alloc_en && (alloc_addr != '0);

  // Set is applied after the clears so a new producer keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (clr0)  busy_nxt[wa0] = 1'b0;
    if (clr1)  busy_nxt[wa1] = 1'b0;
    if (set_a) busy_nxt[alloc_addr] = 1'b1;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr0) regs[wa0] <= wd0;
      if (wr1)  regs[wa1] <= wd1;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd1   = regs[ra1];
    busy1 = busy[ra1];
    if (ra1 == '0) begin
      rd1   = '0;
      busy1 = 1'b0;
    end else if (clr0 && (wa0 == ra1)) begin
      rd1   = wd0;
      busy1 = 1'b0;
    end else if (clr1 && (wa1 == ra1)) begin
      rd1   = wd1;
      busy1 = 1'b0;
    end

    rd2   = regs[ra2];
    busy2 = busy[ra2];
    if (ra2 == '0) begin
      rd2   = '0;
      busy2 = 1'b0;
    end else if (clr0 && (wa0 == ra2)) begin
      rd2   = wd0;
      busy2 = 1'b0;
    end else if (clr1 && (wa1 == ra2)) begin
      rd2   = wd1;
      busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized self-checking bench for reg_file_sb against an associative-array
// model of register contents and pending set, plus a 64x16 parameter sweep.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, alloc_en;
  logic [4:0]  wa0, wa1, ra1, ra2, alloc_addr;
  logic [31:0] wd0, wd1, rd1, rd2;
  logic        busy1, busy2;
  logic [5:0]  busy_cnt;

  logic        s_we0, s_we1, s_alloc_en;
  logic [3:0]  s_wa0, s_wa1, s_ra1, s_ra2, s_alloc_addr;
  logic [63:0] s_wd0, s_wd1, s_rd1, s_rd2;
  logic        s_busy1, s_busy2;
  logic [4:0]  s_busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [int];
  bit          pend [int];
  logic [63:0] exp64 [16];

  reg_file_sb #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.XLEN(64), .NREG(16)) dut_sw (
    .clk(clk), .rst(rst),
    .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
    .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
    .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .alloc_en(s_alloc_en), .alloc_addr(s_alloc_addr),
    .busy1(s_busy1), .busy2(s_busy2), .busy_cnt(s_busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (we0 && wa0 == ra) return wd0;
    if (we1 && wa1 == ra) return wd1;
    return mem.exists(int'(ra)) ? mem[int'(ra)] : 32'h0;
  endfunction

  function automatic logic m_busy(input logic [4:0] ra);
    if ((we0 && wa0 == ra) || (we1 && wa1 == ra)) return 1'b0;
    return pend.exists(int'(ra));
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    ra1 = 0; ra2 = 0; alloc_addr = 0;
  endtask

  task automatic s_idle();
    s_we0 = 0; s_we1 = 0; s_alloc_en = 0;
    s_wa0 = 0; s_wa1 = 0; s_wd0 = 0; s_wd1 = 0;
    s_ra1 = 0; s_ra2 = 0; s_alloc_addr = 0;
  endtask

  task automatic model_reset();
    mem.delete();
    pend.delete();
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model.
  task automatic tick();
    @(negedge clk);
    chk("rd1", rd1, m_rd(ra1));
    chk("rd2", rd2, m_rd(ra2));
    chk("busy1", busy1, m_busy(ra1));
    chk("busy2", busy2, m_busy(ra2));
    chk("busy_cnt", busy_cnt, pend.num());
    @(posedge clk);
    if (!rst) begin
      if (we1 && wa1 != 0) mem[int'(wa1)] = wd1;
      if (we0 && wa0 != 0) mem[int'(wa0)] = wd0;
      if (we0) pend.delete(int'(wa0));
      if (we1) pend.delete(int'(wa1));
      if (alloc_en && alloc_addr != 0) pend[int'(alloc_addr)] = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    s_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cnt", busy_cnt, 0);
    chk("rst_sw_cnt", s_busy_cnt, 0);

    // 64-bit / 16-register sweep
    for (int unsigned i = 1; i < 16; i++) begin
      s_alloc_en = 1; s_alloc_addr = 4'(i);
      @(posedge clk); #1;
    end
    s_idle();
    chk("sw_cnt_full", s_busy_cnt, 15);
    for (int unsigned i = 0; i < 16; i++) begin
      s_idle();
      exp64[i] = {$urandom, $urandom};
      if (i[0]) begin s_we1 = 1; s_wa1 = 4'(i); s_wd1 = exp64[i]; end
      else      begin s_we0 = 1; s_wa0 = 4'(i); s_wd0 = exp64[i]; end
      @(posedge clk); #1;
    end
    exp64[0] = 64'h0;
    s_idle();
    chk("sw_cnt_empty", s_busy_cnt, 0);
    for (int unsigned i = 0; i < 16; i++) begin
      s_ra1 = 4'(i); s_ra2 = 4'(15 - i);
      #1;
      chk("sw_rd1", s_rd1, exp64[i]);
      chk("sw_rd2", s_rd2, exp64[15 - i]);
      chk("sw_busy1", s_busy1, 0);
    end
    s_idle();
    @(posedge clk); #1;

    // Mid-cycle reset clears stored data; bypass stays live during reset
    idle(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    tick();
    idle(); ra1 = 5;
    #2 chk("pre_rst_rd1", rd1, 32'hDEADBEEF);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rd1", rd1, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    @(posedge clk); #1;
    idle(); we0 = 1; wa0 = 4; wd0 = 32'hCAFE0001; ra2 = 4;
    tick();
    idle(); ra2 = 4;
    tick();
    rst = 1'b0;
    chk("rst_no_write", rd2, 0);

    // Writes and allocs to x0 are ignored
    idle(); we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; ra1 = 0;
    tick();
    idle(); ra1 = 0; alloc_en = 1; alloc_addr = 0;
    #1;
    chk("x0_rd1", rd1, 0);
    chk("x0_busy1", busy1, 0);
    tick();
    chk("x0_cnt", busy_cnt, 0);

    // Dual-write conflict on x7
    idle(); we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra1 = 7;
    #3 chk("conflict_byp", rd1, 32'h11);
    tick();
    idle(); ra1 = 7;
    #1 chk("conflict_store", rd1, 32'h11);

    // Scoreboard round trip on x3
    idle(); alloc_en = 1; alloc_addr = 3; ra1 = 3;
    tick();
    idle(); ra1 = 3;
    #1;
    chk("rt_busy1", busy1, 1);
    chk("rt_cnt", busy_cnt, 1);
    we1 = 1; wa1 = 3; wd1 = 32'h55;
    #1;
    chk("rt_byp_busy1", busy1, 0);
    chk("rt_byp_rd1", rd1, 32'h55);
    tick();
    idle();
    chk("rt_cnt_clear", busy_cnt, 0);

    // Alloc/clear collision on x9
    idle(); alloc_en = 1; alloc_addr = 9;
    tick();
    idle(); we0 = 1; wa0 = 9; wd0 = 32'hA; alloc_en = 1; alloc_addr = 9;
    tick();
    idle(); ra1 = 9;
    #1;
    chk("coll_rd1", rd1, 32'hA);
    chk("coll_busy1", busy1, 1);
    chk("coll_cnt", busy_cnt, 1);
    tick();

    // Randomized traffic, addresses biased low to provoke collisions
    for (int n = 0; n < 1500; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      alloc_en = ($urandom_range(0, 9) < 4);
      wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      alloc_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
